mod_segment_mapper: RTL

Parametrised successor to the single-bit, two-segment modulation selector. It accepts M-ary symbols through a valid/ready handshake and uses each symbol to select one of 2^SYM_BITS reference segments held in a runtime-loadable table. For every accepted symbol it emits SEG_LEN registered samples, with optional sign inversion. It sits in the modulation pipe between the bit/symbol packer and the DAC-side sample path.

---
 rtl/mod_segment_mapper_pkg.sv | 28 ++
 rtl/mod_segment_mapper_if.sv | 35 +++
 rtl/mod_segment_mapper_table.sv | 48 ++++
 rtl/mod_segment_mapper.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mod_segment_mapper_pkg.sv
// Shared types, default sizing and the saturating negate used by the
// segment mapper in the modulation pipe.
package mod_pipe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int MOD_WIDTH    = 32;
  localparam int MOD_SYM_BITS = 2;
  localparam int MOD_SEG_LEN  = 8;
  localparam int MOD_MAX_W    = 64;

  // Operates on a sign-extended value so one function serves any width up to
  // MOD_MAX_W; the most negative w-bit value saturates to the most positive.
  function automatic logic [MOD_MAX_W-1:0] sat_negate(input logic [MOD_MAX_W-1:0] x,
                                                      input int unsigned w);
    logic [MOD_MAX_W-1:0] min_v;
    min_v = {MOD_MAX_W{1'b1}} << (w - 32'd1);
    if (x == min_v) begin
      sat_negate = ~min_v;
    end else begin
      sat_negate = -x;
    end
  endfunction

endpackage

// File: rtl/mod_segment_mapper_if.sv
// Symbol input, sample output and table-configuration signals of the
// segment mapper.
interface mod_segment_mapper_if
  import mod_pipe_pkg::*;
#(
  parameter int WIDTH    = MOD_WIDTH,
  parameter int SYM_BITS = MOD_SYM_BITS,
  parameter int IDX_W    = (MOD_SEG_LEN > 1) ? $clog2(MOD_SEG_LEN) : 1
);
  logic                cfg_we;
  logic [SYM_BITS-1:0] cfg_sym;
  logic [IDX_W-1:0]    cfg_idx;
  logic [WIDTH-1:0]    cfg_data;
  logic                cfg_invert;
  logic                in_valid;
  logic                in_ready;
  logic [SYM_BITS-1:0] in_sym;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_last;
  logic                busy;

  modport master (
    output cfg_we, cfg_sym, cfg_idx, cfg_data, cfg_invert,
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  cfg_we, cfg_sym, cfg_idx, cfg_data, cfg_invert,
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/mod_segment_mapper_table.sv
// NUM_SYM x SEG_LEN reference-segment register file: synchronous write,
// combinational read (old data on same-cycle collision), cleared on reset.
module mod_segment_table
  import mod_pipe_pkg::*;
#(
  parameter int WIDTH    = MOD_WIDTH,
  parameter int SYM_BITS = MOD_SYM_BITS,
  parameter int SEG_LEN  = MOD_SEG_LEN,
  parameter int IDX_W    = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we_i,
  input  logic [SYM_BITS-1:0] wr_sym_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic [SYM_BITS-1:0] rd_sym_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [WIDTH-1:0]    rd_data_o
);
  localparam int NUM_SYM = 1 << SYM_BITS;

  logic [WIDTH-1:0] mem_q [NUM_SYM][SEG_LEN];

  // Table storage; out-of-range sample indices are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SYM; s++) begin
        for (int i = 0; i < SEG_LEN; i++) begin
          mem_q[s][i] <= '0;
        end
      end
    end else if (we_i && (32'(wr_idx_i) < 32'(SEG_LEN))) begin
      mem_q[wr_sym_i][wr_idx_i] <= wr_data_i;
    end
  end

  // Read port
  always_comb begin
    rd_data_o = '0;
    if (32'(rd_idx_i) < 32'(SEG_LEN)) begin
      rd_data_o = mem_q[rd_sym_i][rd_idx_i];
    end else begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/mod_segment_mapper.sv
// M-ary symbol to reference-segment mapper: each accepted symbol emits
// SEG_LEN registered samples from a runtime table, optionally negated.
module mod_segment_mapper
  import mod_pipe_pkg::*;
#(
  parameter int WIDTH    = MOD_WIDTH,
  parameter int SYM_BITS = MOD_SYM_BITS,
  parameter int SEG_LEN  = MOD_SEG_LEN,
  parameter int IDX_W    = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_segment_mapper_if.slave  bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEG_LEN - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [SYM_BITS-1:0] sym_q, sym_d;
  logic                inv_q, inv_d;

  logic                in_ready_s;
  logic                accept_s;
  logic                inv_sel_s;
  logic [IDX_W-1:0]    cnt_inc_s;
  logic [SYM_BITS-1:0] rd_sym_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [WIDTH-1:0]    rd_data_s;
  logic [WIDTH-1:0]    samp_s;

  mod_segment_table #(
    .WIDTH    (WIDTH),
    .SYM_BITS (SYM_BITS),
    .SEG_LEN  (SEG_LEN),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .we_i      (bus.cfg_we),
    .wr_sym_i  (bus.cfg_sym),
    .wr_idx_i  (bus.cfg_idx),
    .wr_data_i (bus.cfg_data),
    .rd_sym_i  (rd_sym_s),
    .rd_idx_i  (rd_idx_s),
    .rd_data_o (rd_data_s)
  );

  assign in_ready_s = (state_q == IDLE) || (bus.out_ready && last_q);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign cnt_inc_s  = cnt_q + IDX_W'(1);

  // A new symbol reads its first entry with the invert flag it arrives with
  always_comb begin
    rd_sym_s  = sym_q;
    rd_idx_s  = cnt_inc_s;
    inv_sel_s = inv_q;
    samp_s    = rd_data_s;
    if (accept_s) begin
      rd_sym_s  = bus.in_sym;
      rd_idx_s  = '0;
      inv_sel_s = bus.cfg_invert;
    end else begin
      rd_sym_s  = sym_q;
      rd_idx_s  = cnt_inc_s;
      inv_sel_s = inv_q;
    end
    if (inv_sel_s) begin
      samp_s = WIDTH'(sat_negate(MOD_MAX_W'(signed'(rd_data_s)), WIDTH));
    end else begin
      samp_s = rd_data_s;
    end
  end

  // Emission FSM next state and output-register updates
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EMIT;
          sym_d   = bus.in_sym;
          inv_d   = bus.cfg_invert;
          data_d  = samp_s;
          last_d  = (SEG_LEN == 32'd1);
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (!bus.out_ready) begin
          state_d = EMIT;
        end else if (!last_q) begin
          cnt_d  = cnt_inc_s;
          data_d = samp_s;
          last_d = (cnt_inc_s == LAST_IDX);
        end else if (accept_s) begin
          sym_d  = bus.in_sym;
          inv_d  = bus.cfg_invert;
          data_d = samp_s;
          last_d = (SEG_LEN == 32'd1);
          cnt_d  = '0;
        end else begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      sym_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.busy      = (state_q == EMIT);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

endmodule
